// File: rtl/sc_run_ctrl_pkg.sv
// sc_run_ctrl_pkg: shared definitions for the single-cycle computer run controller.
//   - run_state_e : FSM state encoding, also exported on the state_o port
//   - cnt_width() : counter width helper for the hold/debounce counters
package sc_run_ctrl_pkg;

    typedef enum logic [1:0] {
        StResetHold = 2'd0,
        StHalt      = 2'd1,
        StRun       = 2'd2,
        StStep      = 2'd3
    } run_state_e;

    // Width that can hold 0 .. n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sc_key_debounce.sv
// sc_key_debounce: 2-FF synchronizer, level debouncer and press-pulse generator for one key.
//   clock_i   : board clock
//   resetn_i  : asynchronous active-low reset
//   key_i     : raw active-high key
//   press_o   : 1-cycle pulse on the debounced 0->1 edge
// The debounced level follows the synchronized key only after the two have differed for
// DEBOUNCE_CYCLES consecutive cycles (DEBOUNCE_CYCLES >= 1).
module sc_key_debounce
    import sc_run_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clock_i,
    input  logic resetn_i,
    input  logic key_i,
    output logic press_o
);

    localparam int unsigned        CntW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0]    CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CntMax) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/sc_run_ctrl.sv
// sc_run_ctrl: run controller for the single-cycle computer. Derives the CPU clock from the
// board clock and sequences the CPU through reset hold, halt, free-run and single-step.
//   clock_i       : board clock (same net as the computer's mem_clk)
//   resetn_i      : asynchronous active-low reset
//   run_key_i     : raw key, press starts free-run
//   step_key_i    : raw key, press executes one instruction
//   halt_key_i    : raw key, press stops free-run
//   pc_i          : current CPU PC
//   bp_addr_i     : breakpoint address (SC_RUN_CTRL_BREAKPOINT_EN builds only)
//   cpu_clock_o   : registered CPU clock
//   cpu_resetn_o  : registered CPU reset, active-low
//   state_o       : current FSM state (run_state_e encoding)
//   cycle_count_o : number of cpu_clock rising edges issued, wraps
//   bp_hit_o      : high while halted by the breakpoint
// Optional feature macro: SC_RUN_CTRL_BREAKPOINT_EN enables the PC breakpoint.
module sc_run_ctrl
    import sc_run_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned RESET_HOLD      = 4
) (
    input  logic        clock_i,
    input  logic        resetn_i,
    input  logic        run_key_i,
    input  logic        step_key_i,
    input  logic        halt_key_i,
    input  logic [31:0] pc_i,
`ifdef SC_RUN_CTRL_BREAKPOINT_EN
    input  logic [31:0] bp_addr_i,
`endif
    output logic        cpu_clock_o,
    output logic        cpu_resetn_o,
    output logic [1:0]  state_o,
    output logic [31:0] cycle_count_o,
    output logic        bp_hit_o
);

    localparam int unsigned     HoldW   = cnt_width(RESET_HOLD);
    localparam logic [HoldW-1:0] HoldMax = HoldW'(RESET_HOLD - 1);

    logic run_press, step_press, halt_press;

    sc_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_key (
        .clock_i  (clock_i),
        .resetn_i (resetn_i),
        .key_i    (run_key_i),
        .press_o  (run_press)
    );

    sc_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_key (
        .clock_i  (clock_i),
        .resetn_i (resetn_i),
        .key_i    (step_key_i),
        .press_o  (step_press)
    );

    sc_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_halt_key (
        .clock_i  (clock_i),
        .resetn_i (resetn_i),
        .key_i    (halt_key_i),
        .press_o  (halt_press)
    );

    run_state_e       state_q, state_d;
    logic             cpu_clock_q, cpu_clock_d;
    logic             cpu_resetn_q, cpu_resetn_d;
    logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
    logic             halt_pend_q, halt_pend_d;
    logic [31:0]      cycle_count_q;
    logic             enter_exec;  // leaving HALT for RUN or STEP
    logic             bp_match;    // armed breakpoint compare, only meaningful in RUN low phase
    logic             bp_take;

    always_comb begin
        state_d      = state_q;
        cpu_clock_d  = cpu_clock_q;
        cpu_resetn_d = cpu_resetn_q;
        hold_cnt_d   = '0;
        halt_pend_d  = 1'b0;
        enter_exec   = 1'b0;
        bp_take      = 1'b0;
        unique case (state_q)
            StResetHold: begin
                cpu_clock_d  = 1'b0;
                cpu_resetn_d = 1'b0;
                if (hold_cnt_q == HoldMax) begin
                    state_d      = StHalt;
                    cpu_resetn_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            StHalt: begin
                cpu_clock_d = 1'b0;
                // Halt has priority and simply keeps us here.
                if (!halt_press && step_press) begin
                    state_d     = StStep;
                    cpu_clock_d = 1'b1;
                    enter_exec  = 1'b1;
                end else if (!halt_press && run_press) begin
                    state_d     = StRun;
                    cpu_clock_d = 1'b1;
                    enter_exec  = 1'b1;
                end
            end
            StRun: begin
                if (cpu_clock_q) begin
                    // Falling edge: the only point where a halt may take effect, so a
                    // high phase is never cut short.
                    cpu_clock_d = 1'b0;
                    if (halt_pend_q || halt_press) begin
                        state_d = StHalt;
                    end
                end else if (bp_match) begin
                    // Suppress the rise so the instruction at the breakpoint stays unexecuted.
                    state_d = StHalt;
                    bp_take = 1'b1;
                end else begin
                    cpu_clock_d = 1'b1;
                    halt_pend_d = halt_pend_q | halt_press;
                end
            end
            StStep: begin
                cpu_clock_d = 1'b0;
                state_d     = StHalt;
            end
            default: begin
                state_d     = StResetHold;
                cpu_clock_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q       <= StResetHold;
            cpu_clock_q   <= 1'b0;
            cpu_resetn_q  <= 1'b0;
            hold_cnt_q    <= '0;
            halt_pend_q   <= 1'b0;
            cycle_count_q <= '0;
        end else begin
            state_q      <= state_d;
            cpu_clock_q  <= cpu_clock_d;
            cpu_resetn_q <= cpu_resetn_d;
            hold_cnt_q   <= hold_cnt_d;
            halt_pend_q  <= halt_pend_d;
            if (cpu_clock_d && !cpu_clock_q) begin
                cycle_count_q <= cycle_count_q + 32'd1;
            end
        end
    end

`ifdef SC_RUN_CTRL_BREAKPOINT_EN
    logic armed_q, armed_d;
    logic bp_hit_q, bp_hit_d;

    assign bp_match = armed_q && (pc_i == bp_addr_i);

    // Disarmed on every resume; re-armed once a high phase has been issued, so the
    // instruction sitting at the breakpoint executes on resume.
    always_comb begin
        armed_d  = armed_q;
        bp_hit_d = bp_hit_q;
        if (enter_exec) begin
            armed_d  = 1'b0;
            bp_hit_d = 1'b0;
        end else if (cpu_clock_q) begin
            armed_d = 1'b1;
        end
        if (bp_take) begin
            bp_hit_d = 1'b1;
        end
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            armed_q  <= 1'b0;
            bp_hit_q <= 1'b0;
        end else begin
            armed_q  <= armed_d;
            bp_hit_q <= bp_hit_d;
        end
    end

    assign bp_hit_o = bp_hit_q;
`else
    logic unused_bp;

    assign bp_match  = 1'b0;
    assign bp_hit_o  = 1'b0;
    assign unused_bp = ^{pc_i, enter_exec, bp_take};
`endif

    assign cpu_clock_o   = cpu_clock_q;
    assign cpu_resetn_o  = cpu_resetn_q;
    assign state_o       = state_q;
    assign cycle_count_o = cycle_count_q;

endmodule

// File: tb/tb_sc_run_ctrl.sv
// tb_sc_run_ctrl: scoreboard bench for sc_run_ctrl. Stimulus tasks push the expected state
// transitions (state, cycle_count, bp_hit) into a queue; a monitor pops one entry each time
// the DUT's state output changes. Expected counts come from key timing: a run press followed
// by a halt press g cycles later retires g/2+1 CPU cycles.
module tb_sc_run_ctrl;

    localparam logic [1:0] S_RESET = 2'd0;
    localparam logic [1:0] S_HALT  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_STEP  = 2'd3;

    logic        clock;
    logic        resetn;
    logic        run_key, step_key, halt_key;
    logic [31:0] pc;
    logic        cpu_clock, cpu_resetn, bp_hit;
    logic [1:0]  state;
    logic [31:0] cycle_count;
`ifdef SC_RUN_CTRL_BREAKPOINT_EN
    logic [31:0] bp_addr;
`endif

    sc_run_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .RESET_HOLD      (4)
    ) dut (
        .clock_i       (clock),
        .resetn_i      (resetn),
        .run_key_i     (run_key),
        .step_key_i    (step_key),
        .halt_key_i    (halt_key),
        .pc_i          (pc),
`ifdef SC_RUN_CTRL_BREAKPOINT_EN
        .bp_addr_i     (bp_addr),
`endif
        .cpu_clock_o   (cpu_clock),
        .cpu_resetn_o  (cpu_resetn),
        .state_o       (state),
        .cycle_count_o (cycle_count),
        .bp_hit_o      (bp_hit)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // CPU model: PC advances by 4 on each CPU clock rise.
    always @(posedge cpu_clock or negedge cpu_resetn) begin
        if (!cpu_resetn) pc <= 32'd0;
        else             pc <= pc + 32'd4;
    end

    typedef struct {
        logic [1:0]  st;
        logic [31:0] cnt;
        logic        bp;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned exp_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic push_exp(input logic [1:0] st, input logic [31:0] cnt, input logic bp);
        exp_t e;
        e.st  = st;
        e.cnt = cnt;
        e.bp  = bp;
        exp_q.push_back(e);
    endtask

    // Monitor: every observed state change consumes one expected entry.
    initial begin
        logic [1:0] prev_st;
        logic       prev_clk;
        exp_t       e;
        prev_st  = S_RESET;
        prev_clk = 1'b0;
        forever begin
            @(negedge clock);
            if (state !== prev_st) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_transition", {30'd0, state}, {30'd0, prev_st});
                end else begin
                    e = exp_q.pop_front();
                    chk("state", {30'd0, state}, {30'd0, e.st});
                    chk("cycle_count", cycle_count, e.cnt);
                    chk("bp_hit", {31'd0, bp_hit}, {31'd0, e.bp});
                    chk("cpu_resetn", {31'd0, cpu_resetn}, {31'd0, (e.st != S_RESET)});
                    if (e.st == S_HALT || e.st == S_RESET) begin
                        chk("cpu_clock_low", {31'd0, cpu_clock}, 32'd0);
                    end
                end
            end else if (state == S_RUN) begin
                chk("run_toggle", {31'd0, cpu_clock}, {31'd0, ~prev_clk});
            end
            prev_st  = state;
            prev_clk = cpu_clock;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
        exp_q.delete();
        idle(20);
    endtask

    // Called at a negedge with resetn low.
    task automatic release_reset();
        int n = 0;
        push_exp(S_HALT, 32'd0, 1'b0);
        resetn  = 1'b1;
        exp_cnt = 0;
        while (!cpu_resetn && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("reset_hold_len", n, 4);
        chk("state_after_hold", {30'd0, state}, {30'd0, S_HALT});
        chk("count_after_reset", cycle_count, 32'd0);
        drain();
    endtask

    task automatic do_step();
        push_exp(S_STEP, exp_cnt + 1, 1'b0);
        push_exp(S_HALT, exp_cnt + 1, 1'b0);
        exp_cnt = exp_cnt + 1;
        for (int i = 0; i < 10; i++) begin
            step_key = 1'b1;
            @(negedge clock);
        end
        step_key = 1'b0;
        drain();
        chk("pc_after_step", pc, 4 * exp_cnt);
    endtask

    // Run key rises, halt key rises g cycles later (g == 0: same cycle, halt wins).
    task automatic do_run_halt(input int g);
        if (g > 0) begin
            push_exp(S_RUN, exp_cnt + 1, 1'b0);
            push_exp(S_HALT, exp_cnt + g / 2 + 1, 1'b0);
            exp_cnt = exp_cnt + g / 2 + 1;
        end
        for (int i = 0; i < g + 8; i++) begin
            run_key  = (i < 8);
            halt_key = (i >= g) && (i < g + 8);
            @(negedge clock);
        end
        run_key  = 1'b0;
        halt_key = 1'b0;
        drain();
        chk("pc_after_run", pc, 4 * exp_cnt);
    endtask

    task automatic do_glitch(input int which, input int len);
        for (int i = 0; i < len; i++) begin
            run_key  = (which == 0);
            step_key = (which == 1);
            halt_key = (which == 2);
            @(negedge clock);
        end
        run_key  = 1'b0;
        step_key = 1'b0;
        halt_key = 1'b0;
        drain();
        chk("state_after_glitch", {30'd0, state}, {30'd0, S_HALT});
    endtask

    task automatic do_mid_run_reset();
        int n = 0;
        push_exp(S_RUN, exp_cnt + 1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            run_key = 1'b1;
            @(negedge clock);
        end
        run_key = 1'b0;
        while (!(state == S_RUN && cpu_clock) && n < 40) begin
            @(posedge clock);
            #2;
            n++;
        end
        chk("mid_run_high_reached", {31'd0, (state == S_RUN && cpu_clock)}, 32'd1);
        idle(3);
        @(posedge clock);
        #2;
        push_exp(S_RESET, 32'd0, 1'b0);
        resetn = 1'b0;
        #1;
        chk("async_state", {30'd0, state}, {30'd0, S_RESET});
        chk("async_cpu_clock", {31'd0, cpu_clock}, 32'd0);
        chk("async_cpu_resetn", {31'd0, cpu_resetn}, 32'd0);
        chk("async_cycle_count", cycle_count, 32'd0);
        chk("async_bp_hit", {31'd0, bp_hit}, 32'd0);
        idle(3);
        release_reset();
    endtask

    task automatic random_ops(input int n);
        for (int k = 0; k < n; k++) begin
            case ($urandom_range(0, 3))
                0:       do_step();
                1:       do_run_halt(int'($urandom_range(1, 30)));
                2:       do_glitch(int'($urandom_range(0, 2)), int'($urandom_range(1, 3)));
                default: do_run_halt(0);
            endcase
        end
    endtask

    initial begin
        resetn   = 1'b0;
        run_key  = 1'b0;
        step_key = 1'b0;
        halt_key = 1'b0;
`ifdef SC_RUN_CTRL_BREAKPOINT_EN
        bp_addr  = 32'h0000_000C;
`endif
        idle(3);
        chk("reset_state", {30'd0, state}, {30'd0, S_RESET});
        chk("reset_cpu_resetn", {31'd0, cpu_resetn}, 32'd0);
        release_reset();

`ifdef SC_RUN_CTRL_BREAKPOINT_EN
        // Run into the breakpoint at 0xC, then resume past it.
        push_exp(S_RUN, 32'd1, 1'b0);
        push_exp(S_HALT, 32'd3, 1'b1);
        for (int i = 0; i < 8; i++) begin
            run_key = 1'b1;
            @(negedge clock);
        end
        run_key = 1'b0;
        drain();
        chk("bp_pc", pc, 32'h0000_000C);
        exp_cnt = 3;
        do_run_halt(12);
        chk("bp_passed", {31'd0, (pc > 32'h14)}, 32'd1);
        chk("bp_hit_cleared", {31'd0, bp_hit}, 32'd0);
        bp_addr = 32'hFFFF_FFF0;
`endif

        do_step();
        do_run_halt(20);
        do_glitch(0, 3);
        do_run_halt(0);
        do_run_halt(1);
        do_run_halt(2);
        random_ops(12);
        do_mid_run_reset();
        random_ops(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
